// File: rtl/power_seq_pkg.sv
// Shared types for the power rail sequencer: FSM state encoding and its width.
package power_seq_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    StStable = 3'd0,
    StUpDly  = 3'd1,
    StUpPg   = 3'd2,
    StDnDly  = 3'd3,
    StFault  = 3'd4
  } seq_state_e;

endpackage

// File: rtl/pgood_sync.sv
// Multi-bit flop-chain synchroniser for the asynchronous regulator power-good inputs.
module pgood_sync #(
  parameter int unsigned WIDTH  = 2,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync_q [STAGES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/power_rail_sequencer.sv
// Ordered rail enable sequencer: ascending power-up, descending power-down, pgood timeout
// monitoring and a latched fault that drops every rail until cleared with no requests pending.
module power_rail_sequencer
  import power_seq_pkg::*;
#(
  parameter int unsigned N_RAILS     = 2,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned ON_DELAY    = 1000,
  parameter int unsigned PG_TIMEOUT  = 50000,
  parameter int unsigned OFF_DELAY   = 1000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [N_RAILS-1:0]         req_i,
  input  logic [N_RAILS-1:0]         pgood_i,
  input  logic                       fault_clr_i,
  output logic [N_RAILS-1:0]         rail_en_o,
  output logic                       rails_ok_o,
  output logic                       fault_o,
  output logic [$clog2(N_RAILS)-1:0] fault_rail_o,
  output logic [STATE_W-1:0]         state_o
);

  localparam int unsigned RAIL_W  = $clog2(N_RAILS);
  localparam int unsigned ON_EFF  = (ON_DELAY == 0) ? 1 : ON_DELAY;
  localparam int unsigned PG_EFF  = (PG_TIMEOUT == 0) ? 1 : PG_TIMEOUT;
  localparam int unsigned OFF_EFF = (OFF_DELAY == 0) ? 1 : OFF_DELAY;
  localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;
  localparam logic [CNT_W-1:0] ON_LIM  = CNT_W'(ON_EFF - 1);
  localparam logic [CNT_W-1:0] PG_LIM  = CNT_W'(PG_EFF - 1);
  localparam logic [CNT_W-1:0] OFF_LIM = CNT_W'(OFF_EFF - 1);

  if (longint'(ON_EFF) > CNT_MAX || longint'(PG_EFF) > CNT_MAX ||
      longint'(OFF_EFF) > CNT_MAX) begin : g_cnt_w_check
    $error("CNT_W too narrow for the configured delays");
  end
  if (N_RAILS < 2 || SYNC_STAGES < 2) begin : g_param_check
    $error("N_RAILS and SYNC_STAGES must both be at least 2");
  end

  seq_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RAIL_W-1:0]  cur_q, cur_d;
  logic [N_RAILS-1:0] rail_en_q, rail_en_d;
  logic               fault_q, fault_d;
  logic [RAIL_W-1:0]  fault_rail_q, fault_rail_d;
  logic               rails_ok_q, rails_ok_d;
  logic [N_RAILS-1:0] pg_bad_q;

  logic [N_RAILS-1:0] pgood_s, tgt, pg_bad, pg_fail, next_mask, top_mask;
  logic               up_go, dn_go, stable_fault;
  logic [RAIL_W-1:0]  up_idx, dn_idx, fail_idx;

  pgood_sync #(
    .WIDTH  (N_RAILS),
    .STAGES (SYNC_STAGES)
  ) u_pgood_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (pgood_i),
    .q_o     (pgood_s)
  );

  // Rail k is targeted only when it and every rail below it are requested.
  always_comb begin
    for (int k = 0; k < N_RAILS; k++) begin
      tgt[k] = 1'b1;
      for (int j = 0; j < N_RAILS; j++) begin
        if (j <= k) tgt[k] = tgt[k] & req_i[j];
      end
    end
  end

  // rail_en is a prefix, so the next rail up and the top enabled rail are one-hot masks.
  always_comb begin
    next_mask = ~rail_en_q & {rail_en_q[N_RAILS-2:0], 1'b1};
    top_mask  = rail_en_q & ~{1'b0, rail_en_q[N_RAILS-1:1]};
    pg_bad    = rail_en_q & ~pgood_s;
    pg_fail   = pg_bad & pg_bad_q;
    up_go        = |(next_mask & tgt);
    dn_go        = |(top_mask & ~tgt);
    stable_fault = |pg_fail;
    up_idx   = '0;
    dn_idx   = '0;
    fail_idx = '0;
    for (int k = N_RAILS - 1; k >= 0; k--) begin
      if (next_mask[k]) up_idx = RAIL_W'(k);
      if (top_mask[k])  dn_idx = RAIL_W'(k);
      if (pg_fail[k])   fail_idx = RAIL_W'(k);
    end
  end

  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    rail_en_d    = rail_en_q;
    fault_d      = fault_q;
    fault_rail_d = fault_rail_q;
    unique case (state_q)
      StStable: begin
        if (stable_fault) begin
          state_d      = StFault;
          fault_rail_d = fail_idx;
        end else if (up_go) begin
          cur_d   = up_idx;
          state_d = StUpDly;
        end else if (dn_go) begin
          rail_en_d[dn_idx] = 1'b0;
          cur_d   = dn_idx;
          state_d = StDnDly;
        end
      end
      StUpDly: begin
        if (!tgt[cur_q]) begin
          state_d = StStable;
        end else if (cnt_q == ON_LIM) begin
          rail_en_d[cur_q] = 1'b1;
          state_d = StUpPg;
        end
      end
      StUpPg: begin
        if (pgood_s[cur_q]) begin
          state_d = StStable;
        end else if (!tgt[cur_q]) begin
          rail_en_d[cur_q] = 1'b0;
          state_d = StDnDly;
        end else if (cnt_q == PG_LIM) begin
          state_d      = StFault;
          fault_rail_d = cur_q;
        end
      end
      StDnDly: begin
        if (cnt_q == OFF_LIM) state_d = StStable;
      end
      StFault: begin
        if (fault_clr_i && (req_i == '0)) begin
          fault_d = 1'b0;
          state_d = StStable;
        end
      end
      default: state_d = StStable;
    endcase

    // Crowbar takes effect on the entry edge, not one cycle later.
    if (state_d == StFault) begin
      rail_en_d = '0;
      fault_d   = 1'b1;
    end

    // One shared counter, restarted on every state change and saturating otherwise.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q == {CNT_W{1'b1}}) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    rails_ok_d = (state_q == StStable) && (rail_en_q == tgt) &&
                 (&(pgood_s | ~rail_en_q)) && (state_d != StFault);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StStable;
      cnt_q        <= '0;
      cur_q        <= '0;
      rail_en_q    <= '0;
      fault_q      <= 1'b0;
      fault_rail_q <= '0;
      rails_ok_q   <= 1'b0;
      pg_bad_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cur_q        <= cur_d;
      rail_en_q    <= rail_en_d;
      fault_q      <= fault_d;
      fault_rail_q <= fault_rail_d;
      rails_ok_q   <= rails_ok_d;
      pg_bad_q     <= pg_bad;
    end
  end

  assign rail_en_o    = rail_en_q;
  assign rails_ok_o   = rails_ok_q;
  assign fault_o      = fault_q;
  assign fault_rail_o = fault_rail_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_power_rail_sequencer.sv
// Directed bench for power_rail_sequencer; rail enable transitions are checked against a queue.
module tb_power_rail_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] req;
  logic [1:0] pgood;
  logic       fault_clr;
  logic [1:0] rail_en;
  logic       rails_ok;
  logic       fault;
  logic [0:0] fault_rail;
  logic [2:0] state;

  power_rail_sequencer #(
    .N_RAILS     (2),
    .CNT_W       (16),
    .ON_DELAY    (4),
    .PG_TIMEOUT  (16),
    .OFF_DELAY   (3),
    .SYNC_STAGES (2)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_i        (req),
    .pgood_i      (pgood),
    .fault_clr_i  (fault_clr),
    .rail_en_o    (rail_en),
    .rails_ok_o   (rails_ok),
    .fault_o      (fault),
    .fault_rail_o (fault_rail),
    .state_o      (state)
  );

  always #5 clk = ~clk;

  // Regulator model: pgood follows each enable three cycles later, gated by pg_mask.
  logic [1:0] en_hist [3] = '{2'b00, 2'b00, 2'b00};
  logic [1:0] pg_mask;
  always @(posedge clk) begin
    en_hist[0] <= rail_en;
    en_hist[1] <= en_hist[0];
    en_hist[2] <= en_hist[1];
  end
  assign pgood = en_hist[2] & pg_mask;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [1:0] en;
    int         min_gap;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [1:0] prev_en = 2'b00;
  int last_chg = 0;

  // Every enable change must be the next expected one, spaced at least min_gap cycles on.
  always @(negedge clk) begin
    if (reset_n && rail_en !== prev_en) begin
      check("en_change_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("en_sequence", 32'(rail_en), 32'(mon_e.en));
        check("en_step_gap", 32'((cyc - last_chg) >= mon_e.min_gap), 32'd1);
      end
      prev_en  <= rail_en;
      last_chg <= cyc;
    end
  end

  task automatic push_exp(input logic [1:0] en, input int min_gap);
    exp_t e;
    e.en      = en;
    e.min_gap = min_gap;
    exp_q.push_back(e);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_en(input logic [1:0] v, input int budget, input string tag);
    int n = 0;
    while (rail_en !== v && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(rail_en), 32'(v));
  endtask

  task automatic wait_ok(input int budget, input string tag);
    int n = 0;
    while (rails_ok !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(rails_ok), 32'd1);
  endtask

  task automatic wait_fault(input int budget, input string tag);
    int n = 0;
    while (fault !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(fault), 32'd1);
  endtask

  initial begin
    int n;
    reset_n   = 1'b0;
    req       = 2'b11;
    pg_mask   = 2'b11;
    fault_clr = 1'b0;
    cycles(3);
    check("reset_rail_en", 32'(rail_en), 32'd0);
    check("reset_rails_ok", 32'(rails_ok), 32'd0);
    check("reset_fault", 32'(fault), 32'd0);
    check("reset_fault_rail", 32'(fault_rail), 32'd0);
    check("reset_state", 32'(state), 32'd0);

    // Power-up straight out of reset.
    push_exp(2'b01, 0);
    push_exp(2'b11, 4);
    reset_n = 1'b1;
    wait_en(2'b11, 100, "up_all_on");
    wait_ok(30, "up_rails_ok");
    check("up_fault", 32'(fault), 32'd0);
    check("up_state", 32'(state), 32'd0);

    // One-cycle pgood glitch is tolerated.
    pg_mask = 2'b01;
    cycles(1);
    pg_mask = 2'b11;
    cycles(8);
    check("glitch_fault", 32'(fault), 32'd0);
    check("glitch_en", 32'(rail_en), 32'd3);

    // Two-cycle pgood loss on rail 1 trips the crowbar.
    push_exp(2'b00, 0);
    pg_mask = 2'b01;
    cycles(2);
    pg_mask = 2'b11;
    wait_fault(10, "loss_fault");
    check("loss_fault_rail", 32'(fault_rail), 32'd1);
    check("loss_en", 32'(rail_en), 32'd0);
    check("loss_state", 32'(state), 32'd4);
    check("loss_rails_ok", 32'(rails_ok), 32'd0);

    // Clear with requests pending is ignored; clear with none pending is accepted.
    fault_clr = 1'b1;
    cycles(1);
    fault_clr = 1'b0;
    cycles(2);
    check("clr_ignored_fault", 32'(fault), 32'd1);
    check("clr_ignored_state", 32'(state), 32'd4);
    req = 2'b00;
    cycles(1);
    fault_clr = 1'b1;
    cycles(1);
    fault_clr = 1'b0;
    check("clr_fault", 32'(fault), 32'd0);
    check("clr_state", 32'(state), 32'd0);
    check("clr_en", 32'(rail_en), 32'd0);

    // Power up again, then power down in descending order.
    push_exp(2'b01, 0);
    push_exp(2'b11, 4);
    req = 2'b11;
    wait_en(2'b11, 100, "reup_all_on");
    wait_ok(30, "reup_rails_ok");
    push_exp(2'b01, 0);
    push_exp(2'b00, 3);
    req = 2'b00;
    wait_en(2'b00, 50, "down_all_off");
    check("down_fault", 32'(fault), 32'd0);
    cycles(6);
    check("down_state", 32'(state), 32'd0);

    // Abort a turn-on step during its delay.
    req = 2'b01;
    n = 0;
    while (state !== 3'd1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("abort_in_up_dly", 32'(state), 32'd1);
    cycles(1);
    req = 2'b00;
    cycles(10);
    check("abort_en", 32'(rail_en), 32'd0);
    check("abort_state", 32'(state), 32'd0);

    // Rail 1 alone is never targeted.
    req = 2'b10;
    cycles(15);
    check("prefix_en", 32'(rail_en), 32'd0);
    check("prefix_state", 32'(state), 32'd0);

    // Power-good timeout on rail 0.
    req     = 2'b00;
    pg_mask = 2'b00;
    cycles(2);
    push_exp(2'b01, 0);
    push_exp(2'b00, 0);
    req = 2'b01;
    wait_en(2'b01, 30, "timeout_en_rise");
    n = 0;
    while (fault !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycles", 32'(n), 32'd16);
    check("timeout_fault_rail", 32'(fault_rail), 32'd0);
    check("timeout_en", 32'(rail_en), 32'd0);

    req = 2'b00;
    fault_clr = 1'b1;
    cycles(1);
    fault_clr = 1'b0;
    cycles(1);
    check("final_fault", 32'(fault), 32'd0);
    check("final_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
